// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_pkg
// Description : Shared types and helpers for the FIFO read-side drain controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Occupancy counter width; covers 0..8 buffered words.
    localparam int c_occ_w = 4;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_drain_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_buf
// Description : BUF_DEPTH-entry circular elastic buffer with push/pop and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_buf
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [c_occ_w-1:0]    occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int                 c_ptr_w = clog2(BUF_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [c_occ_w-1:0]    r_occ;
    logic                  w_pop;

    assign w_pop = pop && (r_occ != '0);

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= ptr_next(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_next(r_head);
            end
            if (push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!push && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    assign occ       = r_occ;
    assign head_data = r_mem[r_head];

endmodule
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl
// Description : FIFO read-side controller feeding a valid/ready stream.
//               Define FIFO_DRAIN_PERF_EN to add stall/starve counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  err
`ifdef FIFO_DRAIN_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  starve_cycles
`endif
);

    localparam logic [c_occ_w:0] c_depth = (c_occ_w + 1)'(BUF_DEPTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_words_read;
    logic [c_occ_w-1:0]   w_occ;
    logic [c_occ_w:0]     w_pending;
    logic                 w_pop;

    // Reads already issued count against buffer space so a full buffer never overflows.
    assign w_pending = {1'b0, w_occ} + {{c_occ_w{1'b0}}, r_inflight};
    assign m_valid   = (w_occ != '0);
    assign w_pop     = m_valid && m_ready;
    assign err       = (r_state == ST_ERR);
    assign words_read = r_words_read;

    always_comb begin
        w_state_nxt = r_state;
        fifo_rd_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                fifo_rd_en = !rst && !fifo_empty && (w_pending < c_depth);
                if (fifo_underflow)  w_state_nxt = ST_ERR;
                else if (!enable)    w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (fifo_underflow)                       w_state_nxt = ST_ERR;
                else if ((w_occ == '0) && !r_inflight)    w_state_nxt = ST_IDLE;
                else if (enable)                          w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_inflight   <= 1'b0;
            r_words_read <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                r_words_read <= r_words_read + 1'b1;
            end
        end
    end

    fifo_drain_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (fifo_data_out),
        .pop       (w_pop),
        .occ       (w_occ),
        .head_data (m_data)
    );

`ifdef FIFO_DRAIN_PERF_EN
    logic [CNT_WIDTH-1:0] r_stall;
    logic [CNT_WIDTH-1:0] r_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall  <= '0;
            r_starve <= '0;
        end else begin
            if (m_valid && !m_ready && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
            if ((r_state == ST_RUN) && fifo_empty && (w_occ == '0) && (r_starve != '1)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign stall_cycles  = r_stall;
    assign starve_cycles = r_starve;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_ctrl
// Description : Self-checking bench: behavioural FIFO, queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_ctrl;

    localparam int DW = 16;
    localparam int BD = 3;
    localparam int CW = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_ERR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] words_read;
    logic          err;
`ifdef FIFO_DRAIN_PERF_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] starve_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];     // behavioural FIFO contents
    logic          uf_force;
    int            rd_total;

    int            mode;      // reference model
    logic [DW-1:0] mbuf[$];
    bit            minfl;
    int            mcount;

    typedef struct {
        int       nwords;
        logic     en;
        logic     rdy;
        int       ncyc;
        int       exp_wr;
        int       exp_reads;
        logic     exp_valid;
        logic [DW-1:0] exp_head;
    } vec_t;
    vec_t vt[6];

    always #5 clk = ~clk;

    fifo_drain_ctrl #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .words_read     (words_read),
        .err            (err)
`ifdef FIFO_DRAIN_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .starve_cycles  (starve_cycles)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_edge(input logic r, input logic en, input logic rdy, input bit rd);
        int sz0  = mbuf.size();
        bit inf0 = minfl;
        if (r) begin
            mbuf.delete();
            minfl  = 1'b0;
            mode   = M_IDLE;
            mcount = 0;
            return;
        end
        if (sz0 != 0 && rdy) begin
            void'(mbuf.pop_front());
            mcount++;
        end
        if (inf0) mbuf.push_back(fifo_data_out);
        case (mode)
            M_IDLE: if (en) mode = M_RUN;
            M_RUN:  if (fifo_underflow) mode = M_ERR; else if (!en) mode = M_STOP;
            M_STOP: begin
                if (fifo_underflow)            mode = M_ERR;
                else if (sz0 == 0 && !inf0)    mode = M_IDLE;
                else if (en)                   mode = M_RUN;
            end
            default: mode = M_ERR;
        endcase
        minfl = rd;
    endfunction

    // The behavioural FIFO answers the read sampled at the previous edge.
    task automatic fifo_edge(input logic rd);
        fifo_underflow = (rd && fq.size() == 0) || uf_force;
        uf_force = 1'b0;
        if (rd && fq.size() != 0) fifo_data_out = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        if (rd) rd_total++;
    endtask

    task automatic cyc(input logic r, input logic en, input logic rdy);
        logic rd;
        bit   exp_rd;
        rst = r;
        enable = en;
        m_ready = rdy;
        #1;
        exp_rd = !r && (mode == M_RUN) && (fq.size() != 0) && (mbuf.size() + int'(minfl) < BD);
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("m_valid", 32'(m_valid), 32'(mbuf.size() != 0));
        if (mbuf.size() != 0) chk("m_data", 32'(m_data), 32'(mbuf[0]));
        chk("words_read", 32'(words_read), 32'(mcount[CW-1:0]));
        chk("err", 32'(err), 32'(mode == M_ERR));
        rd = fifo_rd_en;
        model_edge(r, en, rdy, exp_rd);
        @(posedge clk);
        #1;
        fifo_edge(rd);
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic do_reset();
        fq.delete();
        fifo_empty = 1'b1;
        uf_force = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        rd_total = 0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_underflow = 1'b0; fifo_data_out = '0; uf_force = 1'b0;
        mode = M_IDLE; minfl = 1'b0; mcount = 0; rd_total = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_words_read", 32'(words_read), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // {nwords, enable, m_ready, cycles, words_read, reads, m_valid, head}
        vt[0] = '{5, 1'b1, 1'b1, 12, 5, 5, 1'b0, 16'h0000};
        vt[1] = '{8, 1'b1, 1'b0, 10, 0, 3, 1'b1, 16'h0101};
        vt[2] = '{1, 1'b1, 1'b1,  6, 1, 1, 1'b0, 16'h0000};
        vt[3] = '{4, 1'b0, 1'b1,  6, 0, 0, 1'b0, 16'h0000};
        vt[4] = '{0, 1'b1, 1'b1,  5, 0, 0, 1'b0, 16'h0000};
        vt[5] = '{2, 1'b1, 1'b0,  8, 0, 2, 1'b1, 16'h0501};
        for (int t = 0; t < 6; t++) begin
            do_reset();
            load(vt[t].nwords, DW'((t << 8) + 1));
            for (int c = 0; c < vt[t].ncyc; c++) cyc(1'b0, vt[t].en, vt[t].rdy);
            chk("vec_words_read", 32'(words_read), 32'(vt[t].exp_wr));
            chk("vec_reads", 32'(rd_total), 32'(vt[t].exp_reads));
            chk("vec_valid", 32'(m_valid), 32'(vt[t].exp_valid));
            if (vt[t].exp_valid) chk("vec_head", 32'(m_data), 32'(vt[t].exp_head));
        end

        // Backpressure then release: 3 reads while stalled, all 8 delivered in order.
        do_reset();
        load(8, 16'h0A01);
        for (int c = 0; c < 10; c++) cyc(1'b0, 1'b1, 1'b0);
        chk("stall_reads", 32'(rd_total), 32'd3);
        chk("stall_head", 32'(m_data), 32'h0A01);
        for (int c = 0; c < 15; c++) cyc(1'b0, 1'b1, 1'b1);
        chk("stall_words_read", 32'(words_read), 32'd8);

        // Enable dropped the cycle after the first read.
        do_reset();
        load(6, 16'h0B01);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) cyc(1'b0, 1'b0, 1'b1);
        chk("stop_reads", 32'(rd_total), 32'd2);
        chk("stop_words_read", 32'(words_read), 32'd2);
        chk("stop_valid", 32'(m_valid), 32'd0);

        // Underflow while running: sticky error, buffer still drains, reset clears.
        do_reset();
        load(6, 16'h0C01);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        uf_force = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, 1'b1);
        chk("uf_err", 32'(err), 32'd1);
        chk("uf_reads", 32'(rd_total), 32'd3);
        chk("uf_words_read", 32'(words_read), 32'd3);
        cyc(1'b1, 1'b0, 1'b0);
        chk("uf_err_cleared", 32'(err), 32'd0);

        // Reset with two buffered words and one in flight.
        do_reset();
        load(6, 16'h0D01);
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rst6_valid", 32'(m_valid), 32'd0);
        chk("rst6_words_read", 32'(words_read), 32'd0);
        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0);
        chk("rst6_discard", 32'(m_valid), 32'd0);
        for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, 1'b1);
        chk("rst6_resume", 32'(words_read), 32'd3);

        // Randomized traffic against the reference model.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 99) < 40 && fq.size() < 20) begin
                    fq.push_back(DW'($urandom));
                    fifo_empty = 1'b0;
                end
                cyc(1'b0, $urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)));
            end
            for (int c = 0; c < 10; c++) cyc(1'b0, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
